ps2_scan_receiver: RTL
======================

PS2_SCAN_RECEIVER -- requirements
Module: ps2_scan_receiver

Interface
REQ-001 SHALL have parameter DEPTH, default 8, the FIFO entry count (power of two, at least 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, the frame-abort idle limit in clk cycles.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port ps2_clk, input, 1 bit: keyboard clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data, input, 1 bit: keyboard data line, asynchronous to clk.
REQ-007 SHALL have port rd_en, input, 1 bit: pop request from the memory-mapped keyboard register.
REQ-008 SHALL have port rd_data, output, 10 bits: FIFO head as {extended, released, code[7:0]}, first-word fall-through.
REQ-009 SHALL have port empty, output, 1 bit: FIFO holds 0 entries.
REQ-010 SHALL have port full, output, 1 bit: FIFO holds DEPTH entries.
REQ-011 SHALL have port count, output, clog2(DEPTH)+1 bits: current occupancy.
REQ-012 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a parity, stop-bit or timeout error.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, set when a key event is dropped because the FIFO is full.
REQ-014 SHALL have port ovf_clr, input, 1 bit: clears overflow.

Function
REQ-015 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers; a falling edge is sync_prev=1 and sync_cur=0 on the synchronized ps2_clk.
REQ-016 SHALL sample the synchronized ps2_data only in cycles where a ps2_clk falling edge is detected.
REQ-017 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-018 SHALL, in IDLE, go to DATA on an edge with data=0 (start bit); an edge with data=1 leaves it in IDLE.
REQ-019 SHALL, in DATA, shift in 8 bits LSB first, then go to PARITY.
REQ-020 SHALL, in PARITY, capture the bit; odd parity is required, i.e. ones in data plus parity is odd.
REQ-021 SHALL, in STOP, accept the frame if stop=1 and parity is good, otherwise pulse frame_err; the FSM returns to IDLE in either case.
REQ-022 SHALL, when a frame is accepted with code 0xE0, set the ext flag and push nothing.
REQ-023 SHALL, when a frame is accepted with code 0xF0, set the brk flag and push nothing.
REQ-024 SHALL, when any other code is accepted, push {ext, brk, code} and clear ext and brk.
REQ-025 SHALL perform the push on the clock edge after the stop-bit edge cycle; empty falls in that cycle.
REQ-026 SHALL count cycles without a falling edge while outside IDLE; on reaching TIMEOUT_CYCLES it enters IDLE, pulses frame_err and clears ext and brk.
REQ-027 SHALL leave ext and brk unchanged on a parity or stop error.
REQ-028 SHALL pop on rd_en when not empty; rd_en while empty has no effect.
REQ-029 SHALL, on push while full without a pop, drop the entry and set overflow.
REQ-030 SHALL, on simultaneous push and pop, perform both; count is unchanged and overflow is not set even when full.
REQ-031 SHALL wrap the read and write pointers modulo DEPTH.
REQ-032 SHALL keep rd_data at 0 while empty.
REQ-033 SHALL give ovf_clr priority below an overflow event in the same cycle (overflow remains set).

Reset
REQ-034 SHALL, on reset, set the FSM to IDLE, clear the bit counter, timeout counter, ext, brk, pointers and count, and set empty=1, full=0, frame_err=0, overflow=0, rd_data=0.
REQ-035 SHALL, on reset asserted mid-frame, discard the partial frame; the next frame is received from its start bit.

Structure
REQ-036 SHALL place the state enum, prefix constants (0xE0, 0xF0) and the 10-bit entry struct in shared package ps2_pkg.
REQ-037 SHALL implement the FIFO as sub-module ps2_fifo (parameter DEPTH), instantiated once.

Verification
REQ-038 SHALL test: a frame with code 0x1C and correct parity -> one entry 0x01C, empty low 1 cycle after the stop edge.
REQ-039 SHALL test: frames 0xF0 then 0x1C -> a single entry 0x11C.
REQ-040 SHALL test: frames 0xE0, 0xF0, 0x75 -> a single entry 0x375.
REQ-041 SHALL test: a frame with bad parity -> frame_err pulses 1 cycle, no push, next good frame 0x29 -> 0x029.
REQ-042 SHALL test: 9 frames with DEPTH=8 and no reads -> count=8, full=1, overflow=1; ovf_clr -> overflow=0.
REQ-043 SHALL test: ps2_clk held high for TIMEOUT_CYCLES after 4 data bits -> frame_err pulse, FSM in IDLE, next frame accepted.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver and its FIFO.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_entry_t;

endpackage

// File: rtl/ps2_fifo.sv
// First-word fall-through key-event FIFO with a sticky overflow flag.
module ps2_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  ps2_entry_t             wr_data_i,
    input  logic                   pop_i,
    input  logic                   ovf_clr_i,
    output ps2_entry_t             rd_data_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    ps2_entry_t     mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q;
    logic           overflow_q;
    logic           do_push, do_pop, drop;

    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
        do_push = push_i && ((count_q != FULL_CNT) || do_pop);
        drop    = push_i && !do_push;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop)           overflow_q <= 1'b1;
            else if (ovf_clr_i) overflow_q <= 1'b0;
        end
    end

    assign rd_data_o  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == FULL_CNT);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard frame receiver: decodes E0/F0 prefixes and queues key events.
//   state     | meaning
//   ST_IDLE   | waiting for a start bit (data=0 on a ps2_clk fall)
//   ST_DATA   | shifting in 8 data bits, LSB first
//   ST_PARITY | capturing the odd-parity bit
//   ST_STOP   | checking stop bit and parity, then accept or flag error
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ps2_clk,
    input  logic                   ps2_data,
    input  logic                   rd_en,
    output logic [9:0]             rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   frame_err,
    output logic                   overflow,
    input  logic                   ovf_clr
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    clk_s_q, data_s_q;
    logic          clk_prev_q;
    logic          fall, data_s;
    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          timeout, parity_ok, push;
    ps2_entry_t    push_entry, head;

    assign data_s    = data_s_q[1];
    assign fall      = clk_prev_q && !clk_s_q[1];
    assign parity_ok = ^{shift_q, par_q};
    // Down-counter reloads on every edge; terminal count outside IDLE aborts the frame.
    assign timeout   = (state_q != ST_IDLE) && !fall && (tmo_q == '0);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        ext_d      = ext_q;
        brk_d      = brk_q;
        err_d      = 1'b0;
        push       = 1'b0;
        push_entry = '{ext: ext_q, brk: brk_q, code: shift_q};
        tmo_d      = tmo_q;

        if (state_q == ST_IDLE || fall) tmo_d = TMO_LOAD;
        else if (tmo_q != '0)           tmo_d = tmo_q - 1'b1;

        if (timeout) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            err_d     = 1'b1;
            ext_d     = 1'b0;
            brk_d     = 1'b0;
        end else if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!data_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = data_s;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (data_s && parity_ok) begin
                        if (shift_q == PFX_EXT) begin
                            ext_d = 1'b1;
                        end else if (shift_q == PFX_BRK) begin
                            brk_d = 1'b1;
                        end else begin
                            push  = 1'b1;
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s_q    <= 2'b11;
            data_s_q   <= 2'b11;
            clk_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            tmo_q      <= TMO_LOAD;
            err_q      <= 1'b0;
        end else begin
            clk_s_q    <= {clk_s_q[0], ps2_clk};
            data_s_q   <= {data_s_q[0], ps2_data};
            clk_prev_q <= clk_s_q[1];
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
        end
    end

    ps2_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .wr_data_i  (push_entry),
        .pop_i      (rd_en),
        .ovf_clr_i  (ovf_clr),
        .rd_data_o  (head),
        .empty_o    (empty),
        .full_o     (full),
        .count_o    (count),
        .overflow_o (overflow)
    );

    assign rd_data   = head;
    assign frame_err = err_q;

endmodule
